// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATAW = 8;

  typedef enum logic [2:0] {
    BREAK,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int clks_per_bit(input longint freq, input longint baud);
    return int'(freq / baud);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= {WIDTH{RST_VAL}};
      ff2_q <= {WIDTH{RST_VAL}};
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver that writes each good byte into a BRAM FIFO and
// keeps sticky framing/overrun flags for the status register.
//
// state | meaning
// BREAK | line held low (reset or bad stop); wait for idle-high
// IDLE  | waiting for a start edge
// START | timing to mid start bit to reject glitches
// DATA  | sampling data bits at mid-bit
// STOP  | sampling stop bit, then write/drop the byte
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int DATAW        = UART_DATAW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  input  logic             full,
  input  logic             err_clr,
  output logic [DATAW-1:0] data_out,
  output logic             w_en,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [BCW-1:0] BC_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATAW - 1);

  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [BIW-1:0]   bidx_q, bidx_d;
  logic [DATAW-1:0] shreg_q, shreg_d;
  logic [DATAW-1:0] data_q, data_d;
  logic             w_en_q, w_en_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [1:0]       settle_q;
  logic             fe_set, ov_set;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BREAK;
      bcnt_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      w_en_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      settle_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      w_en_q      <= w_en_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      settle_q    <= {settle_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    w_en_d  = 1'b0;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
    case (state_q)
      // The synchronizer resets high, so ignore rx_s until its reset value
      // has been flushed; otherwise a line held low looks like a start edge.
      BREAK: if (settle_q[1] && rx_s) state_d = IDLE;
      IDLE: begin
        bcnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (bcnt_q == BC_HALF) begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          bcnt_d  = '0;
          bidx_d  = '0;
          state_d = DATA;
        end
      end
      DATA: if (bcnt_q == BC_FULL) begin
        shreg_d[bidx_q] = rx_s;
        bcnt_d          = '0;
        if (bidx_q == BI_LAST) state_d = STOP;
        else                   bidx_d  = bidx_q + 1'b1;
      end
      STOP: if (bcnt_q == BC_FULL) begin
        bcnt_d = '0;
        if (!rx_s) begin
          fe_set  = 1'b1;
          state_d = BREAK;
        end else if (full) begin
          ov_set  = 1'b1;
          state_d = IDLE;
        end else begin
          data_d  = shreg_q;
          w_en_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = BREAK;
    endcase
    frame_err_d = fe_set | (frame_err_q & ~err_clr);
    overrun_d   = ov_set | (overrun_q & ~err_clr);
  end

  always_comb begin
    busy      = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    data_out  = data_q;
    w_en      = w_en_q;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Self-checking bench for uart_rx_fifo_feeder with a frame-level reference model.
module tb_uart_rx_fifo_feeder;
  import uart_pkg::*;

  localparam int P  = 16;
  localparam int DW = 8;
  // rx_in edge -> cycle 0 (2), stop sample (P/2 + (DW+1)*P), registered strobe (1)
  localparam int WEN_LAT = 2 + P / 2 + (DW + 1) * P + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          full = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_out;
  logic          w_en, busy, frame_err, overrun;

  uart_rx_fifo_feeder #(.CLKS_PER_BIT(P), .DATAW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .full      (full),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .w_en      (w_en),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] obs_data[$];
  int obs_cyc[$];
  logic wen_prev = 1'b0;
  int wen_double = 0;
  int busy_bad = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (w_en) begin
      obs_data.push_back(data_out);
      obs_cyc.push_back(cyc);
      if (wen_prev) wen_double++;
      if (busy) busy_bad++;
    end
    wen_prev = w_en;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, output int s);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    s = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      tick(P);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1;
    tick(4);
    n_tests++;
    if ({data_out, w_en, busy, frame_err, overrun} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b%b%b%b required all zero", data_out, w_en, busy, frame_err, overrun);
    end
    n_tests++;
    if (dut.state_q !== BREAK) begin n_fail++; $display("FAIL reset_state: got %s required BREAK", dut.state_q.name()); end
    rst = 1'b0;
    tick(4);
    n_tests++;
    if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL idle_after_reset: got %s required IDLE", dut.state_q.name()); end
    // reset released with the line held low must not start a frame
    clear_obs();
    rx_in = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(40);
    n_tests++;
    if (dut.state_q !== BREAK || busy !== 1'b0) begin
      n_fail++; $display("FAIL low_at_release: state %s busy %b required BREAK/0", dut.state_q.name(), busy);
    end
    rx_in = 1'b1;
    tick(4);
    n_tests++;
    if (dut.state_q !== IDLE || obs_data.size() != 0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL break_exit: state %s pulses %0d ferr %b required IDLE/0/0", dut.state_q.name(), obs_data.size(), frame_err);
    end
  endtask

  task automatic test_frame_a5();
    int s;
    clear_obs();
    full = 1'b0;
    drive_frame(8'hA5, 1'b1, s);
    rx_in = 1'b1;
    tick(4);
    last_good = 8'hA5;
    n_tests++;
    if (obs_data.size() != 1) begin
      n_fail++; $display("FAIL a5_count: got %0d pulses required 1", obs_data.size());
    end else begin
      n_tests++;
      if (obs_data[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h required a5", obs_data[0]); end
      n_tests++;
      if (obs_cyc[0] != s + WEN_LAT) begin n_fail++; $display("FAIL a5_timing: got cycle %0d required %0d", obs_cyc[0] - s - 2, WEN_LAT - 2); end
    end
    n_tests++;
    if (data_out !== 8'hA5 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL a5_hold: data %h ferr %b ovr %b required a5/0/0", data_out, frame_err, overrun);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_obs();
    drive_frame(8'h00, 1'b1, s1);
    drive_frame(8'hFF, 1'b1, s2);
    rx_in = 1'b1;
    tick(4);
    last_good = 8'hFF;
    n_tests++;
    if (obs_data.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses required 2", obs_data.size());
    end else begin
      n_tests++;
      if (obs_data[0] !== 8'h00 || obs_data[1] !== 8'hFF) begin
        n_fail++; $display("FAIL b2b_data: got %h %h required 00 ff", obs_data[0], obs_data[1]);
      end
      n_tests++;
      if (obs_cyc[1] - obs_cyc[0] != 10 * P || obs_cyc[0] != s1 + WEN_LAT) begin
        n_fail++; $display("FAIL b2b_spacing: got gap %0d required %0d", obs_cyc[1] - obs_cyc[0], 10 * P);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cnt = 0;
    bit beyond = 0;
    clear_obs();
    for (int i = 0; i < 46; i++) begin
      rx_in = (i < 6) ? 1'b0 : 1'b1;
      tick(1);
      if (busy) busy_cnt++;
      if (dut.state_q == DATA || dut.state_q == STOP) beyond = 1;
    end
    n_tests++;
    if (busy_cnt != P / 2) begin n_fail++; $display("FAIL glitch_busy: got %0d cycles required %0d", busy_cnt, P / 2); end
    n_tests++;
    if (beyond || obs_data.size() != 0) begin
      n_fail++; $display("FAIL glitch_reject: beyond_start %0d pulses %0d required 0/0", beyond, obs_data.size());
    end
  endtask

  task automatic test_frame_err();
    int s;
    clear_obs();
    pulse_clr();
    drive_frame(8'h3C, 1'b0, s);
    tick(20);
    n_tests++;
    if (frame_err !== 1'b1 || obs_data.size() != 0) begin
      n_fail++; $display("FAIL ferr_set: ferr %b pulses %0d required 1/0", frame_err, obs_data.size());
    end
    n_tests++;
    if (dut.state_q !== BREAK || busy !== 1'b0) begin
      n_fail++; $display("FAIL ferr_break: state %s busy %b required BREAK/0", dut.state_q.name(), busy);
    end
    rx_in = 1'b1;
    tick(4);
    drive_frame(8'h11, 1'b1, s);
    rx_in = 1'b1;
    tick(4);
    last_good = 8'h11;
    n_tests++;
    if (obs_data.size() != 1 || data_out !== 8'h11 || frame_err !== 1'b1) begin
      n_fail++; $display("FAIL ferr_next: pulses %0d data %h ferr %b required 1/11/1", obs_data.size(), data_out, frame_err);
    end
    pulse_clr();
    n_tests++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b required 0", frame_err); end
  endtask

  task automatic test_overrun();
    int s;
    clear_obs();
    full = 1'b1;
    drive_frame(8'h5A, 1'b1, s);
    rx_in = 1'b1;
    tick(4);
    n_tests++;
    if (obs_data.size() != 0 || overrun !== 1'b1 || data_out !== last_good) begin
      n_fail++; $display("FAIL ovr_set: pulses %0d ovr %b data %h required 0/1/%h", obs_data.size(), overrun, data_out, last_good);
    end
    // err_clr lands in the stop-sample cycle of a second dropped byte
    fork
      drive_frame(8'($urandom_range(0, 255)), 1'b1, s);
      begin
        tick(WEN_LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
      end
    join
    rx_in = 1'b1;
    tick(4);
    n_tests++;
    if (overrun !== 1'b1 || obs_data.size() != 0 || data_out !== last_good) begin
      n_fail++; $display("FAIL ovr_set_wins: ovr %b pulses %0d data %h required 1/0/%h", overrun, obs_data.size(), data_out, last_good);
    end
    full = 1'b0;
    pulse_clr();
    n_tests++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: ovr %b ferr %b required 0/0", overrun, frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    logic [7:0] b;
    b = 8'hC3;
    clear_obs();
    rx_in = 1'b0;
    tick(P);
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      tick(P);
    end
    rx_in = 1'b0;
    tick(P / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    last_good = 8'h00;
    n_tests++;
    if ({data_out, w_en, busy, frame_err, overrun} !== '0 || dut.state_q !== BREAK) begin
      n_fail++; $display("FAIL midreset_clear: data %h flags %b%b%b%b state %s required zero/BREAK", data_out, w_en, busy, frame_err, overrun, dut.state_q.name());
    end
    tick(12 * P);
    n_tests++;
    if (dut.state_q !== BREAK || obs_data.size() != 0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_hold: state %s pulses %0d ferr %b required BREAK/0/0", dut.state_q.name(), obs_data.size(), frame_err);
    end
    rx_in = 1'b1;
    tick(6);
    drive_frame(8'h81, 1'b1, s);
    rx_in = 1'b1;
    tick(4);
    last_good = 8'h81;
    n_tests++;
    if (obs_data.size() != 1 || data_out !== 8'h81) begin
      n_fail++; $display("FAIL midreset_next: pulses %0d data %h required 1/81", obs_data.size(), data_out);
    end else begin
      n_tests++;
      if (obs_cyc[0] != s + WEN_LAT) begin n_fail++; $display("FAIL midreset_timing: got %0d required %0d", obs_cyc[0] - s, WEN_LAT); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_data[$];
    int exp_cyc[$];
    logic exp_ovr = 1'b0;
    int s;
    clear_obs();
    pulse_clr();
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic f;
      b = 8'($urandom_range(0, 255));
      f = ($urandom_range(0, 3) == 0);
      rx_in = 1'b1;
      tick($urandom_range(0, 12));
      full = f;
      drive_frame(b, 1'b1, s);
      if (f) begin
        exp_ovr = 1'b1;
      end else begin
        exp_data.push_back(b);
        exp_cyc.push_back(s + WEN_LAT);
        last_good = b;
      end
    end
    full = 1'b0;
    rx_in = 1'b1;
    tick(4);
    n_tests++;
    if (obs_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d pulses required %0d", obs_data.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        n_tests++;
        if (obs_data[i] !== exp_data[i] || obs_cyc[i] != exp_cyc[i]) begin
          n_fail++; $display("FAIL rand_byte%0d: got %h @%0d required %h @%0d", i, obs_data[i], obs_cyc[i], exp_data[i], exp_cyc[i]);
        end
      end
    end
    n_tests++;
    if (data_out !== last_good || overrun !== exp_ovr || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rand_status: data %h ovr %b ferr %b required %h/%b/0", data_out, overrun, frame_err, last_good, exp_ovr);
    end
  endtask

  task automatic test_strobe_shape();
    n_tests++;
    if (wen_double != 0) begin n_fail++; $display("FAIL wen_double: got %0d required 0", wen_double); end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL busy_with_wen: got %0d required 0", busy_bad); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_random();
    test_strobe_shape();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
